function_row_sequencer: RTL and testbench

- Parametrised, clocked successor to the fixed 4-row generator-function ROM in the parallel RCE encoder.
- Holds DEPTH writable generator rows of K_N bits and streams a programmed run of rows to the encoder datapath over a valid/ready handshake.
- Optional per-beat cyclic rotation for quasi-cyclic generator expansion.
- Sits between the configuration loader (row writes) and the parallel encoder core (row consumer).

---
 rtl/function_row_sequencer_if.sv | 31 +++
 rtl/function_row_sequencer.sv | 133 +++++++++++++
 tb/tb_function_row_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/function_row_sequencer_if.sv
// Row-write and beat-stream signals between the configuration loader,
// the row sequencer and the encoder core.
interface function_row_sequencer_if #(
  parameter int K_N = 256,
  parameter int AW  = 2,
  parameter int CW  = 8
);
  logic           wr_en;
  logic [AW-1:0]  wr_adrs;
  logic [K_N-1:0] wr_data;
  logic           start;
  logic [1:0]     mode;
  logic [AW-1:0]  adrs;
  logic [CW-1:0]  count;
  logic           ready;
  logic [K_N-1:0] f;
  logic           f_valid;
  logic           f_last;
  logic           f_ready;
  logic           busy;

  modport master (
    output wr_en, wr_adrs, wr_data, start, mode, adrs, count, f_ready,
    input  ready, f, f_valid, f_last, busy
  );

  modport slave (
    input  wr_en, wr_adrs, wr_data, start, mode, adrs, count, f_ready,
    output ready, f, f_valid, f_last, busy
  );
endinterface

// File: rtl/function_row_sequencer.sv
// Writable generator-row store that streams a run of rows (optionally
// cyclically rotated per beat) to the encoder over valid/ready.
module function_row_sequencer #(
  parameter int K_N   = 256,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CW    = 8,
  parameter int SHIFT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  function_row_sequencer_if.slave  bus
);

  localparam int RW = (K_N > 1) ? $clog2(K_N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [K_N-1:0] f_q, f_d;
  logic           f_valid_q, f_valid_d;
  logic           f_last_q, f_last_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  remaining_q, remaining_d;
  logic [RW-1:0]  rot_q, rot_d;
  logic           rot_mode_q, rot_mode_d;

  logic [K_N-1:0] rows [DEPTH];
  logic [CW-1:0]  eff_len;
  logic [RW:0]    rot_sum;
  logic [RW-1:0]  rot_next;
  logic           is_ready;
  logic           transfer;

  // Rows are cleared by reset, so they live in fabric registers rather than RAM.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
    logic [K_N-1:0] row_q, row_d;

    always_comb begin
      row_d = row_q;
      if (bus.wr_en && (bus.wr_adrs == AW'(gi))) row_d = bus.wr_data;
    end

    always_ff @(posedge clk) begin
      if (rst) row_q <= '0;
      else     row_q <= row_d;
    end

    assign rows[gi] = row_q;
  end

  // Bit i of the result is bit (i+r) mod K_N of the source.
  function automatic logic [K_N-1:0] rotr(input logic [K_N-1:0] v, input logic [RW-1:0] r);
    logic [2*K_N-1:0] dbl;
    dbl = {v, v} >> r;
    return dbl[K_N-1:0];
  endfunction

  assign is_ready = (state_q == IDLE) && !f_valid_q;
  assign transfer = f_valid_q && bus.f_ready;
  assign eff_len  = ((bus.mode == 2'b01) || (bus.mode == 2'b10)) ? bus.count : CW'(1);
  assign rot_sum  = {1'b0, rot_q} + (RW+1)'(SHIFT);
  assign rot_next = (rot_sum >= (RW+1)'(K_N)) ? RW'(rot_sum - (RW+1)'(K_N)) : RW'(rot_sum);

  always_comb begin
    state_d     = state_q;
    f_d         = f_q;
    f_valid_d   = f_valid_q;
    f_last_d    = f_last_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    rot_d       = rot_q;
    rot_mode_d  = rot_mode_q;
    case (state_q)
      IDLE: begin
        if (is_ready && bus.start && (eff_len != '0)) begin
          f_d         = rows[bus.adrs];
          f_valid_d   = 1'b1;
          f_last_d    = (eff_len == CW'(1));
          ptr_d       = bus.adrs + AW'(1);
          remaining_d = eff_len - CW'(1);
          rot_d       = RW'(SHIFT);
          rot_mode_d  = (bus.mode == 2'b10);
          if (eff_len > CW'(1)) state_d = RUN;
        end else if (transfer) begin
          // Final beat accepted: f keeps its value, only the qualifiers drop.
          f_valid_d = 1'b0;
          f_last_d  = 1'b0;
        end
      end
      RUN: begin
        if (transfer) begin
          f_d         = rot_mode_q ? rotr(rows[ptr_q], rot_q) : rows[ptr_q];
          f_last_d    = (remaining_q == CW'(1));
          ptr_d       = ptr_q + AW'(1);
          remaining_d = remaining_q - CW'(1);
          rot_d       = rot_next;
          if (remaining_q == CW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      f_q         <= '0;
      f_valid_q   <= 1'b0;
      f_last_q    <= 1'b0;
      ptr_q       <= '0;
      remaining_q <= '0;
      rot_q       <= '0;
      rot_mode_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      f_q         <= f_d;
      f_valid_q   <= f_valid_d;
      f_last_q    <= f_last_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      rot_q       <= rot_d;
      rot_mode_q  <= rot_mode_d;
    end
  end

  assign bus.ready   = is_ready;
  assign bus.busy    = !is_ready;
  assign bus.f       = f_q;
  assign bus.f_valid = f_valid_q;
  assign bus.f_last  = f_last_q;

endmodule

// File: tb/tb_function_row_sequencer.sv
// Directed bench for function_row_sequencer: single, burst wrap, rotate,
// backpressure, zero-length, write collision and mid-run reset.
module tb_function_row_sequencer;
  localparam int K_N = 256;
  localparam int AW  = 2;
  localparam int CW  = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  function_row_sequencer_if #(.K_N(K_N), .AW(AW), .CW(CW)) bus ();

  function_row_sequencer #(
    .K_N(K_N), .DEPTH(4), .AW(AW), .CW(CW), .SHIFT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic [AW-1:0] a, input logic [K_N-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_adrs = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
    $display("write row%0d = %h", a, d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.ready); end
    checks++;
    if (bus.f_valid !== 1'b0) begin errors++; $display("FAIL reset_f_valid got %b exp 0", bus.f_valid); end
    checks++;
    if (bus.f_last !== 1'b0) begin errors++; $display("FAIL reset_f_last got %b exp 0", bus.f_last); end
    checks++;
    if (bus.f !== '0) begin errors++; $display("FAIL reset_f got %h exp 0", bus.f); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    rst = 1'b0;
    $display("reset done");
  endtask

  task automatic test_single();
    logic [K_N-1:0] exp_f;
    exp_f = 256'h4;
    bus.mode    = 2'b00;
    bus.adrs    = 2'd2;
    bus.f_ready = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    $display("single beat f=%h valid=%b last=%b", bus.f, bus.f_valid, bus.f_last);
    checks++;
    if (bus.f !== exp_f) begin errors++; $display("FAIL single_f got %h exp %h", bus.f, exp_f); end
    checks++;
    if (bus.f_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bus.f_valid); end
    checks++;
    if (bus.f_last !== 1'b1) begin errors++; $display("FAIL single_last got %b exp 1", bus.f_last); end
    checks++;
    if (bus.ready !== 1'b0) begin errors++; $display("FAIL single_ready_busy got %b exp 0", bus.ready); end
    tick();
    checks++;
    if (bus.f_valid !== 1'b0) begin errors++; $display("FAIL single_done_valid got %b exp 0", bus.f_valid); end
    checks++;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL single_done_ready got %b exp 1", bus.ready); end
  endtask

  task automatic test_burst_wrap();
    logic [K_N-1:0] exp_tbl [5];
    exp_tbl[0] = 256'h8; exp_tbl[1] = 256'h1; exp_tbl[2] = 256'h2;
    exp_tbl[3] = 256'h4; exp_tbl[4] = 256'h8;
    bus.mode    = 2'b01;
    bus.adrs    = 2'd3;
    bus.count   = 8'd5;
    bus.f_ready = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      $display("burst beat %0d f=%h valid=%b last=%b", k, bus.f, bus.f_valid, bus.f_last);
      checks++;
      if (bus.f !== exp_tbl[k]) begin errors++; $display("FAIL burst_f[%0d] got %h exp %h", k, bus.f, exp_tbl[k]); end
      checks++;
      if (bus.f_valid !== 1'b1) begin errors++; $display("FAIL burst_valid[%0d] got %b exp 1", k, bus.f_valid); end
      checks++;
      if (bus.f_last !== (k == 4)) begin errors++; $display("FAIL burst_last[%0d] got %b exp %b", k, bus.f_last, (k == 4)); end
      tick();
    end
    checks++;
    if (bus.f_valid !== 1'b0) begin errors++; $display("FAIL burst_end_valid got %b exp 0", bus.f_valid); end
    checks++;
    if (bus.f !== exp_tbl[4]) begin errors++; $display("FAIL burst_end_f_hold got %h exp %h", bus.f, exp_tbl[4]); end
    checks++;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL burst_end_ready got %b exp 1", bus.ready); end
  endtask

  task automatic run_rotate(input string tag, input logic [K_N-1:0] exp0, input logic [K_N-1:0] exp1);
    bus.mode    = 2'b10;
    bus.adrs    = 2'd0;
    bus.count   = 8'd2;
    bus.f_ready = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    $display("%s beat 0 f=%h last=%b", tag, bus.f, bus.f_last);
    checks++;
    if (bus.f !== exp0) begin errors++; $display("FAIL %s_beat0 got %h exp %h", tag, bus.f, exp0); end
    checks++;
    if (bus.f_last !== 1'b0) begin errors++; $display("FAIL %s_last0 got %b exp 0", tag, bus.f_last); end
    tick();
    $display("%s beat 1 f=%h last=%b", tag, bus.f, bus.f_last);
    checks++;
    if (bus.f !== exp1) begin errors++; $display("FAIL %s_beat1 got %h exp %h", tag, bus.f, exp1); end
    checks++;
    if (bus.f_last !== 1'b1) begin errors++; $display("FAIL %s_last1 got %b exp 1", tag, bus.f_last); end
    tick();
  endtask

  task automatic test_rotate();
    logic [K_N-1:0] one;
    logic [K_N-1:0] top;
    one = 256'h1;
    top = one << 255;
    run_rotate("rot_a", one, one);
    write_row(2'd1, one);
    run_rotate("rot_b", one, top);
    write_row(2'd1, 256'h2);
  endtask

  task automatic test_backpressure();
    bus.f_ready = 1'b0;
    bus.mode    = 2'b01;
    bus.adrs    = 2'd0;
    bus.count   = 8'd3;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mode  = 2'b00;
      bus.adrs  = 2'd2;
      bus.start = 1'b1;
      tick();
      $display("stall %0d f=%h valid=%b last=%b", i, bus.f, bus.f_valid, bus.f_last);
      checks++;
      if (bus.f !== 256'h1) begin errors++; $display("FAIL stall_f[%0d] got %h exp 1", i, bus.f); end
      checks++;
      if (bus.f_valid !== 1'b1 || bus.f_last !== 1'b0) begin
        errors++; $display("FAIL stall_flags[%0d] got v=%b l=%b exp v=1 l=0", i, bus.f_valid, bus.f_last);
      end
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL stall_busy[%0d] got %b exp 1", i, bus.busy); end
    end
    bus.start   = 1'b0;
    bus.f_ready = 1'b1;
    tick();
    $display("bp beat 1 f=%h last=%b", bus.f, bus.f_last);
    checks++;
    if (bus.f !== 256'h2 || bus.f_last !== 1'b0) begin
      errors++; $display("FAIL bp_beat1 got f=%h l=%b exp f=2 l=0", bus.f, bus.f_last);
    end
    tick();
    $display("bp beat 2 f=%h last=%b", bus.f, bus.f_last);
    checks++;
    if (bus.f !== 256'h4 || bus.f_last !== 1'b1) begin
      errors++; $display("FAIL bp_beat2 got f=%h l=%b exp f=4 l=1", bus.f, bus.f_last);
    end
    tick();
    checks++;
    if (bus.f_valid !== 1'b0 || bus.ready !== 1'b1) begin
      errors++; $display("FAIL bp_end got v=%b r=%b exp v=0 r=1", bus.f_valid, bus.ready);
    end
    tick();
    checks++;
    if (bus.f_valid !== 1'b0) begin errors++; $display("FAIL bp_no_queue got %b exp 0", bus.f_valid); end
  endtask

  task automatic test_count_zero();
    bus.mode  = 2'b01;
    bus.adrs  = 2'd1;
    bus.count = 8'd0;
    bus.start = 1'b1;
    tick();
    $display("count0 start valid=%b ready=%b", bus.f_valid, bus.ready);
    checks++;
    if (bus.f_valid !== 1'b0 || bus.ready !== 1'b1) begin
      errors++; $display("FAIL count0 got v=%b r=%b exp v=0 r=1", bus.f_valid, bus.ready);
    end
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.f_valid !== 1'b0) begin errors++; $display("FAIL count0_after got %b exp 0", bus.f_valid); end
  endtask

  task automatic test_write_during_run();
    bus.mode    = 2'b01;
    bus.adrs    = 2'd0;
    bus.count   = 8'd2;
    bus.f_ready = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_adrs = 2'd1;
    bus.wr_data = 256'h55;
    tick();
    bus.wr_en = 1'b0;
    $display("collide beat f=%h last=%b", bus.f, bus.f_last);
    checks++;
    if (bus.f !== 256'h2) begin errors++; $display("FAIL collide_old got %h exp 2", bus.f); end
    tick();
    bus.mode  = 2'b00;
    bus.adrs  = 2'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    $display("collide reread f=%h", bus.f);
    checks++;
    if (bus.f !== 256'h55) begin errors++; $display("FAIL collide_new got %h exp 55", bus.f); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    bus.mode    = 2'b01;
    bus.adrs    = 2'd0;
    bus.count   = 8'd4;
    bus.f_ready = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.f_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("midrun reset f=%h valid=%b ready=%b", bus.f, bus.f_valid, bus.ready);
    checks++;
    if (bus.f !== '0) begin errors++; $display("FAIL midrst_f got %h exp 0", bus.f); end
    checks++;
    if (bus.f_valid !== 1'b0 || bus.ready !== 1'b1) begin
      errors++; $display("FAIL midrst_flags got v=%b r=%b exp v=0 r=1", bus.f_valid, bus.ready);
    end
    for (int a = 0; a < 4; a++) begin
      bus.mode    = 2'b00;
      bus.adrs    = AW'(a);
      bus.f_ready = 1'b1;
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      $display("cleared row%0d f=%h valid=%b", a, bus.f, bus.f_valid);
      checks++;
      if (bus.f !== '0 || bus.f_valid !== 1'b1) begin
        errors++; $display("FAIL cleared_row%0d got f=%h v=%b exp f=0 v=1", a, bus.f, bus.f_valid);
      end
      tick();
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_adrs = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    bus.mode    = 2'b00;
    bus.adrs    = '0;
    bus.count   = '0;
    bus.f_ready = 1'b0;

    test_reset();
    write_row(2'd0, 256'h1);
    write_row(2'd1, 256'h2);
    write_row(2'd2, 256'h4);
    write_row(2'd3, 256'h8);
    test_single();
    test_burst_wrap();
    test_rotate();
    test_backpressure();
    test_count_zero();
    test_write_during_run();
    test_reset_mid_run();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
